sar_result_avg: RTL and testbench

- Downstream consumer of the 6-bit SAR conversion logic.
- Takes each finished conversion word with a one-cycle done strobe and averages a selectable number of consecutive results (1/2/4/8).
- Pushes each averaged word into a small FIFO, which a readout/host stage drains through a valid/ready handshake.
- Decouples the fixed conversion rate from a slower or bursty consumer and flags lost results.

---
 rtl/sar_result_avg.sv | 117 +++++++++++
 tb/tb_sar_result_avg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sar_result_avg.sv
// Averages 1/2/4/8 consecutive SAR results and queues each average in a small FIFO.
// Latency: one cycle from the window's final conv_done to out_valid; out_valid/out_ready backpressure, words dropped with sticky overflow when full.
module sar_result_avg #(
  parameter int DW       = 6,
  parameter int MAX_LOG2 = 3,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rest,
  input  logic                       conv_done,
  input  logic [DW-1:0]              conv_data,
  input  logic [1:0]                 avg_sel,
  input  logic                       out_ready,
  input  logic                       clr_ovf,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [MAX_LOG2-1:0]        win_cnt,
  output logic                       overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int KW   = $clog2(MAX_LOG2 + 1);
  localparam int ACCW = DW + MAX_LOG2;

  logic [ACCW-1:0]   r_acc;
  logic [MAX_LOG2-1:0] r_win_cnt;
  logic [KW-1:0]     r_k;
  logic [DW-1:0]     r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_overflow;

  logic [KW-1:0]     w_sel_clamp;
  logic [KW-1:0]     w_k;
  logic [MAX_LOG2:0] w_win_len;
  logic              w_last;
  logic [ACCW-1:0]   w_sum;
  logic [ACCW-1:0]   w_shift;
  logic [DW-1:0]     w_avg;
  logic [AW:0]       w_level;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_push_ok;
  logic              w_drop;

  assign w_sel_clamp = (32'(avg_sel) > MAX_LOG2) ? KW'(MAX_LOG2) : KW'(avg_sel);

  // The window exponent is taken live only on the first sample; afterwards the latched copy rules.
  assign w_k       = (r_win_cnt == '0) ? w_sel_clamp : r_k;
  assign w_win_len = (MAX_LOG2 + 1)'(1) << w_k;
  assign w_last    = conv_done && ({1'b0, r_win_cnt} == (w_win_len - (MAX_LOG2 + 1)'(1)));
  assign w_sum     = r_acc + ACCW'(conv_data);
  assign w_shift   = w_sum >> w_k;
  assign w_avg     = w_shift[DW-1:0];

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_level == (AW + 1)'(DEPTH));
  assign w_pop     = out_valid && out_ready;
  assign w_push    = w_last;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rest) begin
      r_acc     <= '0;
      r_win_cnt <= '0;
      r_k       <= '0;
    end else if (conv_done) begin
      if (r_win_cnt == '0) begin
        r_k <= w_sel_clamp;
      end
      if (w_last) begin
        r_acc     <= '0;
        r_win_cnt <= '0;
      end else begin
        r_acc     <= w_sum;
        r_win_cnt <= r_win_cnt + MAX_LOG2'(1);
      end
    end
  end

  // Storage needs no reset: out_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rest && w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_avg;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_valid  = (w_level != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign fifo_level = w_level;
  assign win_cnt    = r_win_cnt;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_sar_result_avg.sv
// Randomized and directed bench for sar_result_avg against a queue-based averaging model.
module tb_sar_result_avg;

  logic       clk;
  logic       rest;
  logic       conv_done;
  logic [5:0] conv_data;
  logic [1:0] avg_sel;
  logic       out_ready;
  logic       clr_ovf;
  logic       out_valid;
  logic [5:0] out_data;
  logic [2:0] fifo_level;
  logic [2:0] win_cnt;
  logic       overflow;

  int n_checks;
  int n_fails;

  // Reference state: running sum, samples so far, window exponent, queue of averages, sticky flag.
  int m_sum;
  int m_cnt;
  int m_k;
  int m_q[$];
  int m_ovf;

  sar_result_avg dut (
    .clk        (clk),
    .rest       (rest),
    .conv_done  (conv_done),
    .conv_data  (conv_data),
    .avg_sel    (avg_sel),
    .out_ready  (out_ready),
    .clr_ovf    (clr_ovf),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .win_cnt    (win_cnt),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit d, input int data, input int sel,
                            input bit rdy, input bit clr);
    int  pre_size;
    bit  pop;
    bit  push;
    int  val;
    if (r) begin
      m_sum = 0; m_cnt = 0; m_k = 0; m_ovf = 0;
      m_q.delete();
      return;
    end
    pre_size = m_q.size();
    pop  = (pre_size > 0) && rdy;
    push = 0;
    val  = 0;
    if (d) begin
      if (m_cnt == 0) m_k = (sel > 3) ? 3 : sel;
      m_sum += data;
      m_cnt++;
      if (m_cnt == (1 << m_k)) begin
        push  = 1;
        val   = (m_sum / (1 << m_k)) % 64;
        m_sum = 0;
        m_cnt = 0;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (pre_size < 4 || pop) m_q.push_back(val);
      else m_ovf = 1;
    end
    if (!(push && pre_size >= 4 && !pop) && clr) m_ovf = 0;
  endtask

  task automatic compare_all();
    check("out_valid", int'(out_valid), (m_q.size() > 0) ? 1 : 0);
    check("out_data", int'(out_data), (m_q.size() > 0) ? m_q[0] : 0);
    check("fifo_level", int'(fifo_level), m_q.size());
    check("win_cnt", int'(win_cnt), m_cnt);
    check("overflow", int'(overflow), m_ovf);
  endtask

  task automatic cyc(input bit r, input bit d, input int data, input int sel,
                     input bit rdy, input bit clr);
    rest      = r;
    conv_done = d;
    conv_data = 6'(data);
    avg_sel   = 2'(sel);
    out_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    model_edge(r, d, data, sel, rdy, clr);
    #1;
    compare_all();
  endtask

  initial begin
    int samp4[4];
    n_checks = 0;
    n_fails  = 0;
    m_sum = 0; m_cnt = 0; m_k = 0; m_ovf = 0;
    rest = 1'b1; conv_done = 1'b0; conv_data = '0; avg_sel = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_data", int'(out_data), 0);

    // Passthrough
    cyc(0, 1, 'h2A, 0, 1, 0);
    check("pass_a", int'(out_data), 'h2A);
    cyc(0, 1, 'h15, 0, 1, 0);
    check("pass_b", int'(out_data), 'h15);
    check("pass_lvl", int'(fifo_level), 1);
    cyc(0, 0, 0, 0, 1, 0);

    // Average of four: 10+11+12+14 = 47, 47>>2 = 11
    samp4 = '{10, 11, 12, 14};
    foreach (samp4[i]) begin
      cyc(0, 1, samp4[i], 2, 0, 0);
      if (i < 3) check("avg4_noout", int'(out_valid), 0);
    end
    check("avg4_val", int'(out_data), 11);
    cyc(0, 0, 0, 0, 1, 0);

    // Eight samples of 63 with no accumulator wrap
    for (int i = 0; i < 8; i++) cyc(0, 1, 63, 3, 0, 0);
    check("max_val", int'(out_data), 63);
    cyc(0, 0, 0, 0, 1, 0);

    // Fill the FIFO and overflow it, then push+pop while full
    for (int i = 1; i <= 5; i++) cyc(0, 1, i, 0, 0, 0);
    check("full_lvl", int'(fifo_level), 4);
    check("full_ovf", int'(overflow), 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("clr_ovf", int'(overflow), 0);
    cyc(0, 1, 9, 0, 0, 1);
    check("clr_vs_drop", int'(overflow), 1);
    cyc(0, 1, 6, 0, 1, 0);
    check("pushpop_lvl", int'(fifo_level), 4);
    check("pushpop_head", int'(out_data), 2);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    check("drained", int'(out_valid), 0);

    // avg_sel change mid-window is ignored: 4+4+8+8 >> 2 = 6
    cyc(0, 1, 4, 2, 1, 0);
    cyc(0, 1, 4, 2, 1, 0);
    cyc(0, 1, 8, 1, 1, 0);
    check("midwin_noout", int'(out_valid), 0);
    cyc(0, 1, 8, 1, 0, 0);
    check("midwin_val", int'(out_data), 6);
    cyc(0, 0, 0, 0, 1, 0);

    // Reset mid-window discards the partial sum
    cyc(0, 1, 50, 2, 0, 0);
    cyc(0, 1, 50, 2, 0, 0);
    cyc(1, 0, 0, 2, 0, 0);
    check("rst_win", int'(win_cnt), 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8, 2, 0, 0);
    check("post_rst_val", int'(out_data), 8);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
          int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
